data_sync_mc: RTL and testbench
===============================

Name: data_sync_mc

Overview:
Multi-channel, parametrised successor to the single-bus data synchroniser. Each of NUM_CH channels carries an unsynchronised WIDTH-bit bus qualified by an enable. The enable passes through a STAGES-deep flop chain and is edge-detected. The bus is captured on the detected event and a one-cycle enable pulse is raised. All channel events are also merged into one valid/ready stream through a round-robin arbiter with per-channel overrun flags; the block sits at every CDC entry point feeding the register file and system control.

Parameters:
WIDTH, 8, data bits per channel
NUM_CH, 4, number of channels (1..16)
STAGES, 2, enable synchroniser depth (minimum 2)
TOGGLE_MODE, 0, 0 = level enable (rising edge is an event); 1 = toggle enable (any transition is an event)

Ports:
CLK  in  1  destination clock; all logic on its rising edge
RST  in  1  synchronous, active-high reset
unsync_bus  in  NUM_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]; required stable while its enable event propagates
bus_enable  in  NUM_CH  asynchronous per-channel qualifier
sync_bus  out  NUM_CH*WIDTH  captured data per channel
enable_pulse  out  NUM_CH  one-cycle strobe per capture
out_valid  out  1  merged stream valid
out_ready  in  1  merged stream ready
out_data  out  WIDTH  merged stream data
out_ch  out  clog2(NUM_CH) (min 1)  source channel of out_data
overrun  out  NUM_CH  sticky: a pending event was overwritten
ovr_clr  in  NUM_CH  clears the matching overrun bit

Behaviour:
- Reset (RST=1 at a CLK edge):
  - clears sync chains, edge-detect flops, sync_bus, enable_pulse, pending flags/data, overrun, out_valid, out_data, out_ch.
  - Round-robin pointer resets to 0.
- Per channel:
  - sync chain s[0..STAGES-1]; prev flop samples s[STAGES-1].
  - Event = s_last & ~prev (level mode) or s_last ^ prev (toggle mode).
- Latency:
  - bus_enable changes before edge 1.
  - Event is combinationally true after edge STAGES.
  - At edge STAGES+1: sync_bus <= unsync_bus and enable_pulse <= 1, for exactly one cycle.
  - Without an event, sync_bus holds its value.
- Level mode: a held-high enable gives one event only; bus changes while the enable stays high are ignored.
- Toggle mode: back-to-back events are allowed if transitions are ≥2 cycles apart.
- Enable high through reset release: in level mode this produces an event STAGES+1 edges after release. In toggle mode it also produces one event, because prev resets to 0.
- Merge path:
  - enable_pulse[i] also loads pend_data[i] and sets pending[i].
  - The output slot is free when !out_valid or (out_valid & out_ready).
  - When the slot is free, the arbiter grants the first pending channel at or after the pointer, wrapping. It loads out_data/out_ch, sets out_valid, clears pending[grant], and sets ptr <= grant+1 mod NUM_CH.
  - With no pending channel, out_valid drops after a handshake.
  - A capture and the grant of the same channel in the same cycle: the old data is granted and the new data becomes pending; no overrun.
  - A capture while pending[i]=1 and channel i is not granted: pend_data is overwritten with the newest data and overrun[i] <= 1.
  - ovr_clr[i] clears overrun[i]; a simultaneous set wins.
- out_data/out_ch are stable while out_valid & !out_ready.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DATA_SYNC_MC_PARITY_EN.
- Defined: extra output port out_par (1 bit), registered with out_data, equal to even parity (XOR) of the granted word. It is cleared on reset.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package data_sync_pkg:
  - constant DS_MIN_STAGES=2
  - enum ds_mode_e {DS_LEVEL, DS_TOGGLE}
  - function ds_clog2 with a minimum result of 1
- Sub-module data_sync_ch: one channel's sync chain, edge detect, capture register and pulse. The top generates NUM_CH instances and contains the pending/overrun logic and the arbiter.

Test Plan:
1. Reset with bus_enable=4'hF held (NUM_CH=4, STAGES=2, WIDTH=8) -> all outputs 0 during reset; in level mode, enable_pulse=4'hF for one cycle at the 3rd edge after release.
2. Level capture: ch0 bus=0xAA, enable 0->1 before edge 1 -> enable_pulse[0] high only after edge 3 and sync_bus[7:0]=0xAA. Then bus->0xFF with enable held -> no pulse, 0xAA held.
3. TOGGLE_MODE=1, ch1: enable toggled with data 0x11, then 4 cycles later toggled with data 0x22 -> two single-cycle pulses; sync_bus ch1 = 0x11 then 0x22.
4. Arbitration: ch1, ch2, ch3 capture in the same cycle, out_ready=1 -> out_ch 1, 2, 3 on consecutive cycles with matching data; ptr ends at 0.
5. Backpressure/overrun: out_ready=0; ch2 events 0x10, 0x20, 0x30 -> slot holds 0x10 and overrun[2]=1 after 0x30. out_ready=1 -> 0x10 then 0x30 delivered. ovr_clr[2] pulse -> overrun[2]=0.
6. RST asserted one cycle after ch0 enable rises (mid-chain) -> no pulse; all state cleared. An enable still high at release gives a pulse 3 edges later.

Source files
------------

// File: rtl/data_sync_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : data_sync_pkg
//  Purpose  : Shared constants, mode enum and width helper for data_sync_mc.
//  Revision : 1.0 - initial release
// ============================================================================
package data_sync_pkg;

  // Shallowest enable synchroniser that still resolves metastability.
  localparam int DS_MIN_STAGES = 2;

  typedef enum logic {
    DS_LEVEL  = 1'b0,
    DS_TOGGLE = 1'b1
  } ds_mode_e;

  // Ceiling log2 that never returns less than 1, so a single-channel build
  // still gets a 1-bit channel index.
  function automatic int ds_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage : data_sync_pkg
`default_nettype wire

// File: rtl/data_sync_ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : data_sync_ch
//  Purpose  : One channel: enable synchroniser chain, edge detector, bus
//             capture register and one-cycle capture strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] unsync_bus,
  input  logic             bus_enable,
  output logic [WIDTH-1:0] sync_bus,
  output logic             enable_pulse
);

  // Depth is clamped so a too-small STAGES cannot remove the synchroniser.
  localparam int       SYNC_STAGES = (STAGES < DS_MIN_STAGES) ? DS_MIN_STAGES : STAGES;
  localparam ds_mode_e MODE        = (TOGGLE_MODE != 0) ? DS_TOGGLE : DS_LEVEL;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [WIDTH-1:0]       bus_q, bus_d;
  logic                   pulse_q, pulse_d;
  logic                   evt;
  logic                   s_last;

  // Shift the enable through the chain, detect the event, capture on it.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus_enable};
    s_last  = sync_q[SYNC_STAGES-1];
    prev_d  = s_last;
    evt     = (MODE == DS_TOGGLE) ? (s_last ^ prev_d ^ prev_d ^ prev_q) : (s_last & ~prev_q);
    bus_d   = evt ? unsync_bus : bus_q;
    pulse_d = evt;
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      bus_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      bus_q   <= bus_d;
      pulse_q <= pulse_d;
    end
  end

  assign sync_bus     = bus_q;
  assign enable_pulse = pulse_q;

endmodule : data_sync_ch
`default_nettype wire

// File: rtl/data_sync_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : data_sync_mc
//  Purpose  : NUM_CH enable-qualified bus synchronisers whose captures are
//             merged into one valid/ready stream by a round-robin arbiter,
//             with sticky per-channel overrun flags.
//  Options  : DATA_SYNC_MC_PARITY_EN adds out_par, the XOR of out_data.
//  Revision : 1.0 - initial release
// ============================================================================
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_CH      = 4,
  parameter int STAGES      = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*WIDTH-1:0]     unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  output logic [NUM_CH*WIDTH-1:0]     sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [ds_clog2(NUM_CH)-1:0] out_ch,
  output logic [NUM_CH-1:0]           overrun,
`ifdef DATA_SYNC_MC_PARITY_EN
  output logic                        out_par,
`endif
  input  logic [NUM_CH-1:0]           ovr_clr
);

  localparam int CH_W = ds_clog2(NUM_CH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      data_sync_ch #(
        .WIDTH       (WIDTH),
        .STAGES      (STAGES),
        .TOGGLE_MODE (TOGGLE_MODE)
      ) u_ch (
        .CLK          (CLK),
        .RST          (RST),
        .unsync_bus   (unsync_bus[gi*WIDTH +: WIDTH]),
        .bus_enable   (bus_enable[gi]),
        .sync_bus     (sync_bus[gi*WIDTH +: WIDTH]),
        .enable_pulse (enable_pulse[gi])
      );
    end
  endgenerate

  logic [NUM_CH-1:0]            pending_q, pending_d;
  logic [NUM_CH-1:0][WIDTH-1:0] pend_data_q, pend_data_d;
  logic [NUM_CH-1:0]            overrun_q, overrun_d;
  logic                         out_valid_q, out_valid_d;
  logic [WIDTH-1:0]             out_data_q, out_data_d;
  logic [CH_W-1:0]              out_ch_q, out_ch_d;
  logic [CH_W-1:0]              ptr_q, ptr_d;
`ifdef DATA_SYNC_MC_PARITY_EN
  logic                         par_q, par_d;
`endif

  logic                         slot_free;
  logic                         found;
  logic [CH_W-1:0]              gnt;
  logic [NUM_CH-1:0]            gnt_oh;

  // Round-robin search: first pending channel at or after the pointer.
  always_comb begin : arb
    int              idx;
    logic [CH_W-1:0] idx_w;
    slot_free = !out_valid_q || out_ready;
    found     = 1'b0;
    gnt       = '0;
    gnt_oh    = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx   = (int'(ptr_q) + k) % NUM_CH;
      idx_w = CH_W'(idx);
      if (!found && pending_q[idx_w]) begin
        found = 1'b1;
        gnt   = idx_w;
      end
    end
    if (slot_free && found) gnt_oh[gnt] = 1'b1;
  end

  // Output slot load, pending capture and overrun bookkeeping.
  always_comb begin
    pending_d   = pending_q;
    pend_data_d = pend_data_q;
    overrun_d   = overrun_q & ~ovr_clr;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
`ifdef DATA_SYNC_MC_PARITY_EN
    par_d       = par_q;
`endif
    if (slot_free) begin
      out_valid_d = found;
      if (found) begin
        out_data_d     = pend_data_q[gnt];
        out_ch_d       = gnt;
        pending_d[gnt] = 1'b0;
        ptr_d          = CH_W'((int'(gnt) + 1) % NUM_CH);
`ifdef DATA_SYNC_MC_PARITY_EN
        par_d          = ^pend_data_q[gnt];
`endif
      end
    end
    // A capture on the channel being granted this cycle is a fresh entry,
    // not an overwrite: the old word leaves through the slot.
    for (int i = 0; i < NUM_CH; i++) begin
      if (enable_pulse[i]) begin
        pend_data_d[i] = sync_bus[i*WIDTH +: WIDTH];
        pending_d[i]   = 1'b1;
        if (pending_q[i] && !gnt_oh[i]) overrun_d[i] = 1'b1;
      end
    end
  end

  // Merge path registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q   <= '0;
      pend_data_q <= '0;
      overrun_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
`ifdef DATA_SYNC_MC_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      pending_q   <= pending_d;
      pend_data_q <= pend_data_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
`ifdef DATA_SYNC_MC_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign overrun   = overrun_q;
`ifdef DATA_SYNC_MC_PARITY_EN
  assign out_par   = par_q;
`endif

endmodule : data_sync_mc
`default_nettype wire

// File: tb/tb_data_sync_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_data_sync_mc
//  Purpose  : Directed self-checking bench for data_sync_mc: one level-mode
//             and one toggle-mode instance (WIDTH=8, NUM_CH=4, STAGES=2).
//  Options  : DATA_SYNC_MC_PARITY_EN also checks out_par.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_sync_mc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic [31:0] l_bus, t_bus;
  logic [3:0]  l_en, t_en, l_clr, t_clr;
  logic        l_ready, t_ready;
  logic [31:0] l_sync, t_sync;
  logic [3:0]  l_pulse, t_pulse, l_ovr, t_ovr;
  logic        l_valid, t_valid;
  logic [7:0]  l_data, t_data;
  logic [1:0]  l_ch, t_ch;
`ifdef DATA_SYNC_MC_PARITY_EN
  logic        l_par, t_par;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  data_sync_mc #(.WIDTH(8), .NUM_CH(4), .STAGES(2), .TOGGLE_MODE(0)) dut_l (
    .CLK(CLK), .RST(RST), .unsync_bus(l_bus), .bus_enable(l_en),
    .sync_bus(l_sync), .enable_pulse(l_pulse), .out_valid(l_valid),
    .out_ready(l_ready), .out_data(l_data), .out_ch(l_ch), .overrun(l_ovr),
`ifdef DATA_SYNC_MC_PARITY_EN
    .out_par(l_par),
`endif
    .ovr_clr(l_clr)
  );

  data_sync_mc #(.WIDTH(8), .NUM_CH(4), .STAGES(2), .TOGGLE_MODE(1)) dut_t (
    .CLK(CLK), .RST(RST), .unsync_bus(t_bus), .bus_enable(t_en),
    .sync_bus(t_sync), .enable_pulse(t_pulse), .out_valid(t_valid),
    .out_ready(t_ready), .out_data(t_data), .out_ch(t_ch), .overrun(t_ovr),
`ifdef DATA_SYNC_MC_PARITY_EN
    .out_par(t_par),
`endif
    .ovr_clr(t_clr)
  );

  typedef struct {
    logic [3:0]  en;
    logic [31:0] bus;
    logic [3:0]  exp_pulse;
    logic [31:0] exp_sync;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t tab_rst[9];
  vec_t tab_tog[10];
  vec_t tab_lvl[7];
  vec_t tab_arb[8];

  function automatic vec_t mk(input logic [3:0] en, input logic [31:0] bus,
                              input logic [3:0] p, input logic [31:0] s,
                              input logic v, input logic [7:0] d, input logic [1:0] c);
    vec_t r;
    r.en = en; r.bus = bus; r.exp_pulse = p; r.exp_sync = s;
    r.exp_valid = v; r.exp_data = d; r.exp_ch = c;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one row's inputs, clock once, compare the selected instance.
  task automatic run_row(input string tag, input int n, input vec_t v, input bit tog);
    logic [3:0]  p;
    logic [31:0] s;
    logic        vl;
    logic [7:0]  d;
    logic [1:0]  c;
    if (tog) begin t_en = v.en; t_bus = v.bus; end
    else     begin l_en = v.en; l_bus = v.bus; end
    tick();
    p  = tog ? t_pulse : l_pulse;
    s  = tog ? t_sync  : l_sync;
    vl = tog ? t_valid : l_valid;
    d  = tog ? t_data  : l_data;
    c  = tog ? t_ch    : l_ch;
    chk($sformatf("%s[%0d] pulse", tag, n), {28'd0, p}, {28'd0, v.exp_pulse});
    chk($sformatf("%s[%0d] sync",  tag, n), s, v.exp_sync);
    chk($sformatf("%s[%0d] valid", tag, n), {31'd0, vl}, {31'd0, v.exp_valid});
    if (v.exp_valid) begin
      chk($sformatf("%s[%0d] data", tag, n), {24'd0, d}, {24'd0, v.exp_data});
      chk($sformatf("%s[%0d] ch",   tag, n), {30'd0, c}, {30'd0, v.exp_ch});
`ifdef DATA_SYNC_MC_PARITY_EN
      chk($sformatf("%s[%0d] par", tag, n), {31'd0, (tog ? t_par : l_par)}, {31'd0, ^v.exp_data});
`endif
    end
  endtask

  // One level-mode event on a level-instance channel: raise, hold, drop.
  task automatic lvl_event(input int ch, input logic [7:0] d);
    l_bus[ch*8 +: 8] = d;
    l_en[ch] = 1'b1;
    repeat (4) tick();
    l_en[ch] = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Enable held high through reset, released: all four channels fire.
    tab_rst[0] = mk(4'hF, 32'h44332211, 4'h0, 32'h00000000, 1'b0, 8'h00, 2'd0);
    tab_rst[1] = mk(4'hF, 32'h44332211, 4'h0, 32'h00000000, 1'b0, 8'h00, 2'd0);
    tab_rst[2] = mk(4'hF, 32'h44332211, 4'hF, 32'h44332211, 1'b0, 8'h00, 2'd0);
    tab_rst[3] = mk(4'hF, 32'h44332211, 4'h0, 32'h44332211, 1'b0, 8'h00, 2'd0);
    tab_rst[4] = mk(4'hF, 32'h44332211, 4'h0, 32'h44332211, 1'b1, 8'h11, 2'd0);
    tab_rst[5] = mk(4'hF, 32'h44332211, 4'h0, 32'h44332211, 1'b1, 8'h22, 2'd1);
    tab_rst[6] = mk(4'hF, 32'h44332211, 4'h0, 32'h44332211, 1'b1, 8'h33, 2'd2);
    tab_rst[7] = mk(4'hF, 32'h44332211, 4'h0, 32'h44332211, 1'b1, 8'h44, 2'd3);
    tab_rst[8] = mk(4'hF, 32'h44332211, 4'h0, 32'h44332211, 1'b0, 8'h00, 2'd0);
    // Toggle instance, channel 1: rise then fall, four cycles apart.
    tab_tog[0] = mk(4'h2, 32'h00001100, 4'h0, 32'h00000000, 1'b0, 8'h00, 2'd0);
    tab_tog[1] = mk(4'h2, 32'h00001100, 4'h0, 32'h00000000, 1'b0, 8'h00, 2'd0);
    tab_tog[2] = mk(4'h2, 32'h00001100, 4'h2, 32'h00001100, 1'b0, 8'h00, 2'd0);
    tab_tog[3] = mk(4'h2, 32'h00001100, 4'h0, 32'h00001100, 1'b0, 8'h00, 2'd0);
    tab_tog[4] = mk(4'h0, 32'h00002200, 4'h0, 32'h00001100, 1'b1, 8'h11, 2'd1);
    tab_tog[5] = mk(4'h0, 32'h00002200, 4'h0, 32'h00001100, 1'b0, 8'h00, 2'd0);
    tab_tog[6] = mk(4'h0, 32'h00002200, 4'h2, 32'h00002200, 1'b0, 8'h00, 2'd0);
    tab_tog[7] = mk(4'h0, 32'h00002200, 4'h0, 32'h00002200, 1'b0, 8'h00, 2'd0);
    tab_tog[8] = mk(4'h0, 32'h00002200, 4'h0, 32'h00002200, 1'b1, 8'h22, 2'd1);
    tab_tog[9] = mk(4'h0, 32'h00002200, 4'h0, 32'h00002200, 1'b0, 8'h00, 2'd0);
    // Level instance, channel 0: one capture, later bus change ignored.
    tab_lvl[0] = mk(4'h1, 32'h443322AA, 4'h0, 32'h44332211, 1'b0, 8'h00, 2'd0);
    tab_lvl[1] = mk(4'h1, 32'h443322AA, 4'h0, 32'h44332211, 1'b0, 8'h00, 2'd0);
    tab_lvl[2] = mk(4'h1, 32'h443322AA, 4'h1, 32'h443322AA, 1'b0, 8'h00, 2'd0);
    tab_lvl[3] = mk(4'h1, 32'h443322FF, 4'h0, 32'h443322AA, 1'b0, 8'h00, 2'd0);
    tab_lvl[4] = mk(4'h1, 32'h443322FF, 4'h0, 32'h443322AA, 1'b1, 8'hAA, 2'd0);
    tab_lvl[5] = mk(4'h1, 32'h443322FF, 4'h0, 32'h443322AA, 1'b0, 8'h00, 2'd0);
    tab_lvl[6] = mk(4'h1, 32'h443322FF, 4'h0, 32'h443322AA, 1'b0, 8'h00, 2'd0);
    // Channels 1..3 capture together; pointer sits at 1 after channel 0.
    tab_arb[0] = mk(4'hE, 32'h3CA55AFF, 4'h0, 32'h443322AA, 1'b0, 8'h00, 2'd0);
    tab_arb[1] = mk(4'hE, 32'h3CA55AFF, 4'h0, 32'h443322AA, 1'b0, 8'h00, 2'd0);
    tab_arb[2] = mk(4'hE, 32'h3CA55AFF, 4'hE, 32'h3CA55AAA, 1'b0, 8'h00, 2'd0);
    tab_arb[3] = mk(4'hE, 32'h3CA55AFF, 4'h0, 32'h3CA55AAA, 1'b0, 8'h00, 2'd0);
    tab_arb[4] = mk(4'hE, 32'h3CA55AFF, 4'h0, 32'h3CA55AAA, 1'b1, 8'h5A, 2'd1);
    tab_arb[5] = mk(4'hE, 32'h3CA55AFF, 4'h0, 32'h3CA55AAA, 1'b1, 8'hA5, 2'd2);
    tab_arb[6] = mk(4'hE, 32'h3CA55AFF, 4'h0, 32'h3CA55AAA, 1'b1, 8'h3C, 2'd3);
    tab_arb[7] = mk(4'hE, 32'h3CA55AFF, 4'h0, 32'h3CA55AAA, 1'b0, 8'h00, 2'd0);

    l_bus = 32'h44332211; l_en = 4'hF; l_ready = 1'b1; l_clr = 4'h0;
    t_bus = 32'h0;        t_en = 4'h0; t_ready = 1'b1; t_clr = 4'h0;
    RST = 1'b1;
    repeat (3) tick();

    // Reset state of both instances.
    chk("rst l sync",  l_sync, 32'h0);
    chk("rst l pulse", {28'd0, l_pulse}, 32'h0);
    chk("rst l valid", {31'd0, l_valid}, 32'h0);
    chk("rst l data",  {24'd0, l_data}, 32'h0);
    chk("rst l ch",    {30'd0, l_ch}, 32'h0);
    chk("rst l ovr",   {28'd0, l_ovr}, 32'h0);
    chk("rst t sync",  t_sync, 32'h0);
    chk("rst t valid", {31'd0, t_valid}, 32'h0);
    RST = 1'b0;
    for (int i = 0; i < 9; i++) run_row("rst_rel", i, tab_rst[i], 1'b0);

    l_en = 4'h0;
    repeat (4) tick();
    chk("idle pulse", {28'd0, l_pulse}, 32'h0);

    for (int i = 0; i < 10; i++) run_row("toggle", i, tab_tog[i], 1'b1);
    for (int i = 0; i < 7; i++)  run_row("level", i, tab_lvl[i], 1'b0);

    l_en = 4'h0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++)  run_row("arb", i, tab_arb[i], 1'b0);

    // Pointer back at 0: channel 0 must win over channel 3.
    l_en = 4'h0;
    repeat (4) tick();
    l_bus = 32'h03A55A01;
    l_en  = 4'h9;
    repeat (5) tick();
    chk("ptr0 data", {24'd0, l_data}, 32'h01);
    chk("ptr0 ch",   {30'd0, l_ch}, 32'd0);
    tick();
    chk("ptr3 data", {24'd0, l_data}, 32'h03);
    chk("ptr3 ch",   {30'd0, l_ch}, 32'd3);
    l_en = 4'h0;
    repeat (4) tick();
    chk("ptr idle valid", {31'd0, l_valid}, 32'h0);

    // Backpressure on channel 2 with overwrite of a pending word.
    l_ready = 1'b0;
    lvl_event(2, 8'h10);
    chk("bp1 valid", {31'd0, l_valid}, 32'h1);
    chk("bp1 data",  {24'd0, l_data}, 32'h10);
    chk("bp1 ch",    {30'd0, l_ch}, 32'd2);
    lvl_event(2, 8'h20);
    chk("bp2 data",  {24'd0, l_data}, 32'h10);
    chk("bp2 ovr",   {28'd0, l_ovr}, 32'h0);
    lvl_event(2, 8'h30);
    chk("bp3 data",  {24'd0, l_data}, 32'h10);
    chk("bp3 ovr",   {28'd0, l_ovr}, 32'h4);
    l_ready = 1'b1;
    tick();
    chk("bp4 valid", {31'd0, l_valid}, 32'h1);
    chk("bp4 data",  {24'd0, l_data}, 32'h30);
    chk("bp4 ovr",   {28'd0, l_ovr}, 32'h4);
    tick();
    chk("bp5 valid", {31'd0, l_valid}, 32'h0);
    l_clr = 4'h4;
    tick();
    l_clr = 4'h0;
    chk("ovr clr",   {28'd0, l_ovr}, 32'h0);

    // Reset one edge into channel 0's synchroniser, enable kept high.
    l_bus = 32'h00000077;
    l_en  = 4'h1;
    tick();
    RST = 1'b1;
    tick();
    chk("mid rst pulse", {28'd0, l_pulse}, 32'h0);
    chk("mid rst sync",  l_sync, 32'h0);
    chk("mid rst data",  {24'd0, l_data}, 32'h0);
    chk("mid rst ch",    {30'd0, l_ch}, 32'h0);
    tick();
    RST = 1'b0;
    tick();
    chk("rel e1 pulse", {28'd0, l_pulse}, 32'h0);
    tick();
    chk("rel e2 pulse", {28'd0, l_pulse}, 32'h0);
    tick();
    chk("rel e3 pulse", {28'd0, l_pulse}, 32'h1);
    chk("rel e3 sync",  l_sync, 32'h00000077);
    tick();
    chk("rel e4 pulse", {28'd0, l_pulse}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_sync_mc
`default_nettype wire
